// File: rtl/cla_pkg.sv
// Shared types for the sequential carry-lookahead adder: FSM state encoding
// and the nibble type handled by the 4-bit lookahead slice.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cla_state_t;

    localparam int NIB_W = 4;

    typedef logic [NIB_W-1:0] nib_t;

endpackage

// File: rtl/cla_nibble.sv
// Purely combinational 4-bit carry-lookahead slice. All four carries are
// formed in one level from generate/propagate terms; nothing ripples.
// c[3] is the group carry out of the nibble.
module cla_nibble
    import cla_pkg::*;
(
    input  nib_t       a,
    input  nib_t       b,
    input  logic       cin,
    output nib_t       s,
    output logic [3:0] c
);

    nib_t g;
    nib_t p;

    assign g = a & b;
    assign p = a | b;

    // Flattened lookahead equations: each carry depends only on g, p and cin.
    always_comb begin
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    end

    assign s = a ^ b ^ {c[2:0], cin};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice is reused once per
// nibble, least significant first, with the group carry held in a register
// between steps. valid/ready handshake on both sides, no result overlap.
// Optional build macro: CLA_SEQ_OVF_EN adds the registered signed-overflow
// output ovf.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble per cycle through the slice
// DONE  | result presented, held until out_ready
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cout,
`ifdef CLA_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] sum
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_width_check
        $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    cla_state_t      state;
    cla_state_t      state_nxt;
    nib_t [NIB-1:0]  a_reg;
    nib_t [NIB-1:0]  b_reg;
    nib_t [NIB-1:0]  sum_reg;
    logic            carry_reg;
    idx_t            idx;
    logic            cout_reg;
    nib_t            nib_s;
    logic [3:0]      nib_c;
    logic            accept;
    logic            last;

    // Only the group carry (and c2 for overflow) leaves the slice.
`ifdef CLA_SEQ_OVF_EN
    logic            ovf_reg;
    logic [1:0]      nib_c_unused;
    assign nib_c_unused = nib_c[1:0];
`else
    logic [2:0]      nib_c_unused;
    assign nib_c_unused = nib_c[2:0];
`endif

    cla_nibble u_nibble (
        .a   (a_reg[idx]),
        .b   (b_reg[idx]),
        .cin (carry_reg),
        .s   (nib_s),
        .c   (nib_c)
    );

    assign accept = in_valid && in_ready;
    assign last   = (idx == idx_t'(NIB - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; out_ready only matters in DONE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture at the handshake, then one nibble step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            cout_reg  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
                        ovf_reg   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    sum_reg[idx] <= nib_s;
                    carry_reg    <= nib_c[3];
                    if (last) begin
                        cout_reg <= nib_c[3];
`ifdef CLA_SEQ_OVF_EN
                        ovf_reg  <= nib_c[3] ^ nib_c[2];
`endif
                    end else begin
                        idx <= idx + idx_t'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
`ifdef CLA_SEQ_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed cases followed by random
// back-to-back operations, each compared against plain integer addition.
// Build with CLA_SEQ_OVF_EN defined to also check the ovf output.
module tb_cla_seq_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic         cout;
    logic [W-1:0] sum;
`ifdef CLA_SEQ_OVF_EN
    logic         ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cout      (cout),
`ifdef CLA_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .sum       (sum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. hold = cycles out_ready stays low in DONE,
    // gap = idle cycles before presenting, noisy = random in_valid/out_ready
    // activity while the adder is busy (must all be ignored).
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input int hold, input int gap,
                          input bit noisy);
        logic [W:0] full;
        logic       ovf_exp;
        int         lat;
        int         w;
        bit         busy_ok;
        full    = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        ovf_exp = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);

        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < gap; i++) tick();

        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();

        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 3 * NIB) begin
            if (in_ready) busy_ok = 1'b0;
            if (noisy) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
                a         = W'($urandom);
                b         = W'($urandom);
            end
            tick();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", lat, NIB);
        chk("busy_not_ready", {31'd0, busy_ok}, 32'd1);
        chk("sum", {16'd0, sum}, {16'd0, full[W-1:0]});
        chk("cout", {31'd0, cout}, {31'd0, full[W]});
`ifdef CLA_SEQ_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, ovf_exp});
`endif

        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, full[W-1:0]});
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end

        // Release; a competing in_valid in DONE must not be taken.
        if (noisy) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("released_valid", {31'd0, out_valid}, 32'd0);
        chk("released_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 0, 1, 1'b0);
        run_op(16'hA5A5, 16'h5A5A, 1'b0, 3, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 0, 1'b0);

        // Abort in the middle of RUN (idx 2).
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, 0, 1'b0);

        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 0, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b1, 0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
